// File: rtl/fifo_rd_port.sv
// rtl/fifo_rd_port.sv - FIFO read-side controller with 2-entry skid buffer
// Optional pointer-overrun check: define FIFO_RD_CHECK_EN to build the sticky err flag.
module fifo_rd_port #(
   parameter int K     = 3,
   parameter int W     = 8,
   parameter int AE_TH = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [K:0]   wr_ptr,
   output logic [K:0]   rd_ptr,
   output logic         mem_ren,
   output logic [K-1:0] mem_raddr,
   input  logic [W-1:0] mem_rdata,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready,
   input  logic         flush,
   output logic         empty,
   output logic         almost_empty,
   output logic [K:0]   level,
   output logic         err
);

   logic [K:0]   r_rd_ptr;
   logic [1:0]   r_count;
   logic         r_inflight;
   logic         r_valid;
   logic [W-1:0] r_buf0;
   logic [W-1:0] r_buf1;

   logic         w_pop;
   logic         w_empty;
   logic [K:0]   w_level;
   logic [2:0]   w_occ;
   logic         w_ren;

   // Occupancy after this edge: buffered words plus the one arriving minus the one leaving.
   assign w_pop   = r_valid && out_ready;
   assign w_empty = (r_rd_ptr == wr_ptr);
   assign w_level = wr_ptr - r_rd_ptr;
   assign w_occ   = {1'b0, r_count} + {2'b00, r_inflight} - {2'b00, w_pop};
   assign w_ren   = !rst && !flush && !w_empty && (w_occ < 3'd2);

   assign rd_ptr       = r_rd_ptr;
   assign mem_ren      = w_ren;
   assign mem_raddr    = r_rd_ptr[K-1:0];
   assign out_data     = r_buf0;
   assign out_valid    = r_valid;
   assign empty        = w_empty;
   assign level        = w_level;
   assign almost_empty = (w_level <= (K+1)'(AE_TH));

   // Read pointer, in-flight tracking and skid occupancy; flush resyncs to the writer.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_rd_ptr   <= '0;
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
         r_valid    <= 1'b0;
      end else if (flush) begin
         r_rd_ptr   <= wr_ptr;
         r_count    <= 2'd0;
         r_inflight <= 1'b0;
         r_valid    <= 1'b0;
      end else begin
         r_inflight <= w_ren;
         if (w_ren) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= w_occ[1:0];
         r_valid <= (w_occ != 3'd0);
      end
   end

   // Skid storage: buf0 is always the oldest word, buf1 the younger one.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_buf0 <= '0;
         r_buf1 <= '0;
      end else if (!flush) begin
         if (r_inflight && !w_pop) begin
            if (r_count == 2'd0) begin
               r_buf0 <= mem_rdata;
            end else begin
               r_buf1 <= mem_rdata;
            end
         end else if (!r_inflight && w_pop) begin
            r_buf0 <= r_buf1;
         end else if (r_inflight && w_pop) begin
            if (r_count == 2'd1) begin
               r_buf0 <= mem_rdata;
            end else begin
               r_buf0 <= r_buf1;
               r_buf1 <= mem_rdata;
            end
         end
      end
   end

`ifdef FIFO_RD_CHECK_EN
   logic r_err;

   // Sticky overrun flag: more than a full FIFO between the pointers is impossible.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err <= 1'b0;
      end else if (w_level > {1'b1, {K{1'b0}}}) begin
         r_err <= 1'b1;
      end
   end

   assign err = r_err;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_port.sv
// tb/tb_fifo_rd_port.sv - scoreboard bench for fifo_rd_port
module tb_fifo_rd_port;
   localparam int K = 3;
   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [K:0]   wr_ptr;
   logic [K:0]   rd_ptr;
   logic         mem_ren;
   logic [K-1:0] mem_raddr;
   logic [W-1:0] mem_rdata;
   logic [W-1:0] out_data;
   logic         out_valid;
   logic         out_ready;
   logic         flush;
   logic         empty;
   logic         almost_empty;
   logic [K:0]   level;
   logic         err;

   int n_tests = 0;
   int n_fail  = 0;
   logic [W-1:0] exp_q[$];
   logic [W-1:0] mem [0:7];

   fifo_rd_port #(.K(K), .W(W), .AE_TH(1)) dut (
      .clk(clk), .rst(rst), .wr_ptr(wr_ptr), .rd_ptr(rd_ptr),
      .mem_ren(mem_ren), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .flush(flush), .empty(empty), .almost_empty(almost_empty),
      .level(level), .err(err)
   );

   always #5 clk = ~clk;

   // synchronous-read RAM model
   always @(posedge clk) begin
      if (mem_ren) mem_rdata <= mem[mem_raddr];
   end

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // monitor: every accepted word must match the head of the scoreboard
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_word", int'(out_data), -1);
         end else begin
            chk("data_order", int'(out_data), int'(exp_q.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; wr_ptr = '0; out_ready = 1'b0;
      tick();
      tick();
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic push_exp(input int first, input int n);
      for (int i = 0; i < n; i++) exp_q.push_back(mem[(first + i) % 8]);
   endtask

   task automatic wait_idle(input string name);
      int cyc;
      cyc = 0;
      while ((out_valid || !empty) && cyc < 40) begin
         tick();
         cyc++;
      end
      chk(name, int'(cyc < 40), 1);
   endtask

   initial begin
      for (int i = 0; i < 8; i++) mem[i] = 8'hA0 + 8'(i * 3);
      mem_rdata = '0;

      // 1: reset state and idle empty FIFO
      rst = 1'b1; flush = 1'b0; wr_ptr = '0; out_ready = 1'b0;
      tick();
      @(negedge clk);
      chk("rst_mem_ren", mem_ren, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_rd_ptr", rd_ptr, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_err", err, 0);
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t1_empty", empty, 1);
         chk("t1_level", level, 0);
         chk("t1_almost_empty", almost_empty, 1);
         chk("t1_mem_ren", mem_ren, 0);
         chk("t1_out_valid", out_valid, 0);
         tick();
      end

      // 2: three words, latency and issue addresses
      out_ready = 1'b1;
      wr_ptr = 4'd3;
      push_exp(0, 3);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t2_mem_ren", mem_ren, 1);
         chk("t2_raddr", mem_raddr, i);
         chk("t2_out_valid", out_valid, int'(i == 2));
         tick();
      end
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("t2_valid_hold", out_valid, 1);
         chk("t2_no_ren", mem_ren, 0);
         tick();
      end
      @(negedge clk);
      chk("t2_valid_fall", out_valid, 0);
      chk("t2_rd_ptr", rd_ptr, 3);
      chk("t2_empty", empty, 1);
      chk("t2_drained", exp_q.size(), 0);

      // 3: full FIFO with stalled consumer, then back-to-back drain
      do_reset();
      wr_ptr = 4'd8;
      push_exp(0, 8);
      for (int i = 0; i < 5; i++) tick();
      @(negedge clk);
      chk("t3_rd_ptr", rd_ptr, 2);
      chk("t3_level", level, 6);
      chk("t3_mem_ren", mem_ren, 0);
      chk("t3_out_valid", out_valid, 1);
      chk("t3_head", out_data, mem[0]);
      tick();
      out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         chk("t3_no_gap", out_valid, 1);
         tick();
      end
      @(negedge clk);
      chk("t3_valid_fall", out_valid, 0);
      chk("t3_rd_ptr_end", rd_ptr, 8);
      chk("t3_drained", exp_q.size(), 0);

      // 4: pointer wrap via flush preload
      tick();
      flush = 1'b1; wr_ptr = 4'd14;
      tick();
      flush = 1'b0;
      @(negedge clk);
      chk("t4_preload", rd_ptr, 14);
      tick();
      wr_ptr = 4'd2;
      exp_q.push_back(mem[6]); exp_q.push_back(mem[7]);
      exp_q.push_back(mem[0]); exp_q.push_back(mem[1]);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t4_mem_ren", mem_ren, 1);
         chk("t4_raddr", mem_raddr, (6 + i) % 8);
         tick();
      end
      wait_idle("t4_timeout");
      @(negedge clk);
      chk("t4_rd_ptr", rd_ptr, 2);
      chk("t4_drained", exp_q.size(), 0);

      // 5: flush with data buffered and a read in flight
      do_reset();
      wr_ptr = 4'd5;
      tick();
      tick();
      @(negedge clk);
      chk("t5_pre_valid", out_valid, 1);
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("t5_out_valid", out_valid, 0);
      chk("t5_rd_ptr", rd_ptr, 5);
      chk("t5_empty", empty, 1);
      chk("t5_mem_ren", mem_ren, 0);
      for (int i = 0; i < 3; i++) begin
         tick();
         @(negedge clk);
         chk("t5_no_stale", out_valid, 0);
      end

      // 6: overrun check
      do_reset();
      wr_ptr = 4'd9;
      @(negedge clk);
      chk("t6_err_pre", err, 0);
      tick();
      @(negedge clk);
`ifdef FIFO_RD_CHECK_EN
      chk("t6_err_set", err, 1);
`else
      chk("t6_err_off", err, 0);
`endif
      tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      @(negedge clk);
`ifdef FIFO_RD_CHECK_EN
      chk("t6_err_sticky", err, 1);
`else
      chk("t6_err_off_flush", err, 0);
`endif
      chk("t6_flush_empty", empty, 1);
      do_reset();
      @(negedge clk);
      chk("t6_err_rst", err, 0);

      tick();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
